// File: rtl/teach_pkg.sv
// Shared types and defaults for the piano-teaching step sequencer.
// Imported by the song RAM and the sequencer top.
package teach_pkg;

  localparam int DEF_N_KEYS    = 25;
  localparam int DEF_MAX_STEPS = 64;

  // ST_LOAD is the one-cycle read-latency substate ahead of WAIT_PRESS
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT_PRESS,
    ST_HOLD,
    ST_WAIT_RELEASE,
    ST_DONE
  } teach_state_e;

endpackage

// File: rtl/teach_song_ram.sv
// Song memory: one write port, one registered read port.
// Contents are intentionally not reset.
module teach_song_ram
  import teach_pkg::*;
#(
  parameter int N_KEYS = DEF_N_KEYS,
  parameter int DEPTH  = DEF_MAX_STEPS,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [N_KEYS-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr,
  output logic [N_KEYS-1:0] o_rdata
);

  logic [N_KEYS-1:0] mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) mem[i_waddr] <= i_wdata;
    o_rdata <= mem[i_raddr];
  end

endmodule

// File: rtl/teach_sequencer.sv
// Step sequencer: presents target chords, checks the key vector,
// advances on press-hold-release, counts mistakes and timeouts.
module teach_sequencer
  import teach_pkg::*;
#(
  parameter int N_KEYS      = DEF_N_KEYS,
  parameter int MAX_STEPS   = DEF_MAX_STEPS,
  parameter int HOLD_CYC    = 1000,
  parameter int TIMEOUT_CYC = 50_000_000,
  parameter int ERR_W       = 8,
  parameter int CW          = $clog2(MAX_STEPS)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [N_KEYS-1:0] GPI,
  input  logic              i_wr_en,
  input  logic [CW-1:0]     i_wr_addr,
  input  logic [N_KEYS-1:0] i_wr_data,
  input  logic [CW:0]       i_len,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic              i_timed,
  input  logic              i_loop,
  output logic [N_KEYS-1:0] o_note,
  output logic [CW-1:0]     o_cnt,
  output logic              o_ok,
  output logic              o_wrong,
  output logic [ERR_W-1:0]  o_err_cnt,
  output logic              o_busy,
  output logic              o_done
);

  localparam int LW = CW + 1;
  localparam int HW = $clog2(HOLD_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  teach_state_e state_q, state_d;

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [LW-1:0]     len_q;
  logic              timed_q, loop_q;
  logic [HW-1:0]     hold_q, hold_d;
  logic [TW-1:0]     tmr_q, tmr_d;
  logic [ERR_W-1:0]  err_q;
  logic [ERR_W+1:0]  err_sum;
  logic              wprev_q;
  logic              show_q;
  logic [N_KEYS-1:0] tgt;

  logic idle_like, start_go, match, last;
  logic wrong_now, wrong_edge, timeout, adv;
  logic ok_d, busy_d, done_d, show_d;

  teach_song_ram #(
    .N_KEYS (N_KEYS),
    .DEPTH  (MAX_STEPS),
    .AW     (CW)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (i_wr_en && idle_like),
    .i_waddr (i_wr_addr),
    .i_wdata (i_wr_data),
    .i_raddr (cnt_q),
    .o_rdata (tgt)
  );

  assign idle_like = (state_q == ST_IDLE) ||
                     (state_q == ST_DONE);
  assign start_go  = i_start && idle_like && !i_abort &&
                     (i_len != '0) &&
                     (i_len <= LW'(MAX_STEPS));
  assign match     = (GPI == tgt);
  assign last      = ({1'b0, cnt_q} == len_q - 1'b1);
  assign wrong_now = |(GPI & ~tgt);
  assign wrong_edge = wrong_now && !wprev_q &&
                      ((state_q == ST_WAIT_PRESS) ||
                       (state_q == ST_HOLD));
  assign timeout   = timed_q &&
                     (state_q == ST_WAIT_PRESS) &&
                     (tmr_q >= TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    tmr_d   = tmr_q;
    adv     = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_go) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
        end
      end
      ST_LOAD: begin
        state_d = ST_WAIT_PRESS;
        tmr_d   = '0;
        hold_d  = '0;
      end
      ST_WAIT_PRESS: begin
        if (tmr_q < TW'(TIMEOUT_CYC - 1))
          tmr_d = tmr_q + 1'b1;
        if (timeout) begin
          adv = 1'b1;
        end else if (match) begin
          state_d = ST_HOLD;
          hold_d  = '0;
        end
      end
      ST_HOLD: begin
        if (tmr_q < TW'(TIMEOUT_CYC - 1))
          tmr_d = tmr_q + 1'b1;
        if (!match)
          state_d = ST_WAIT_PRESS;
        else if (hold_q == HW'(HOLD_CYC - 1))
          state_d = ST_WAIT_RELEASE;
        else
          hold_d = hold_q + 1'b1;
      end
      ST_WAIT_RELEASE: begin
        if (!match) adv = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    if (adv) begin
      tmr_d = '0;
      if (!last) begin
        cnt_d   = cnt_q + 1'b1;
        state_d = ST_LOAD;
      end else if (loop_q) begin
        cnt_d   = '0;
        state_d = ST_LOAD;
      end else begin
        state_d = ST_DONE;
      end
    end
    if (i_abort) begin
      state_d = ST_IDLE;
      cnt_d   = cnt_q;
    end
  end

  always_comb begin
    busy_d = 1'b0;
    done_d = 1'b0;
    ok_d   = 1'b0;
    show_d = 1'b0;
    unique case (state_d)
      ST_LOAD:         busy_d = 1'b1;
      ST_WAIT_PRESS,
      ST_HOLD: begin
        busy_d = 1'b1;
        show_d = 1'b1;
      end
      ST_WAIT_RELEASE: begin
        busy_d = 1'b1;
        show_d = 1'b1;
        ok_d   = 1'b1;
      end
      ST_DONE:         done_d = 1'b1;
      default:         busy_d = 1'b0;
    endcase
  end

  // timeout and wrong edge may land together: add both, then saturate
  assign err_sum = {2'b00, err_q} +
                   (ERR_W+2)'(wrong_edge) +
                   (ERR_W+2)'(timeout);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q   <= '0;
      len_q   <= '0;
      timed_q <= 1'b0;
      loop_q  <= 1'b0;
      hold_q  <= '0;
      tmr_q   <= '0;
      err_q   <= '0;
      wprev_q <= 1'b0;
      show_q  <= 1'b0;
      o_ok    <= 1'b0;
      o_wrong <= 1'b0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      tmr_q   <= tmr_d;
      wprev_q <= wrong_now;
      show_q  <= show_d;
      o_ok    <= ok_d;
      o_busy  <= busy_d;
      o_done  <= done_d;
      o_wrong <= wrong_edge && !i_abort;
      if (start_go) begin
        len_q   <= i_len;
        timed_q <= i_timed;
        loop_q  <= i_loop;
        err_q   <= '0;
      end else if (!i_abort) begin
        err_q <= (|err_sum[ERR_W+1:ERR_W]) ?
                 '1 : err_sum[ERR_W-1:0];
      end
    end
  end

  assign o_note    = show_q ? tgt : '0;
  assign o_cnt     = cnt_q;
  assign o_err_cnt = err_q;

endmodule

// File: tb/tb_teach_sequencer.sv
// Directed bench for teach_sequencer with short hold/timeout
// so every lesson scenario fits in a few thousand cycles.
module tb_teach_sequencer;

  localparam int NK  = 25;
  localparam int MS  = 64;
  localparam int HC  = 8;
  localparam int TO  = 100;
  localparam int EW  = 8;
  localparam int CW  = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NK-1:0] gpi = '0;
  logic          wr_en = 1'b0;
  logic [CW-1:0] wr_addr = '0;
  logic [NK-1:0] wr_data = '0;
  logic [CW:0]   len = '0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          timed = 1'b0;
  logic          loop_m = 1'b0;
  logic [NK-1:0] note;
  logic [CW-1:0] cnt;
  logic          ok, wrong, busy, done;
  logic [EW-1:0] err;

  int checks = 0;
  int failures = 0;
  logic [NK-1:0] song [3];

  always #5 clk = ~clk;

  teach_sequencer #(
    .N_KEYS      (NK),
    .MAX_STEPS   (MS),
    .HOLD_CYC    (HC),
    .TIMEOUT_CYC (TO),
    .ERR_W       (EW)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .GPI       (gpi),
    .i_wr_en   (wr_en),
    .i_wr_addr (wr_addr),
    .i_wr_data (wr_data),
    .i_len     (len),
    .i_start   (start),
    .i_abort   (abort),
    .i_timed   (timed),
    .i_loop    (loop_m),
    .o_note    (note),
    .o_cnt     (cnt),
    .o_ok      (ok),
    .o_wrong   (wrong),
    .o_err_cnt (err),
    .o_busy    (busy),
    .o_done    (done)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [CW-1:0] a,
                    input logic [NK-1:0] d);
    wr_en = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick(1);
    wr_en = 1'b0;
  endtask

  task automatic go(input logic [CW:0] l,
                    input logic t,
                    input logic lp);
    len = l;
    timed = t;
    loop_m = lp;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
  endtask

  // full press: match in WAIT_PRESS + HC hold cycles, then release
  task automatic play(input string tag,
                      input logic [NK-1:0] ch);
    gpi = ch;
    tick(HC + 2);
    chk({tag, "_ok"}, 32'(ok), 32'd1);
    gpi = '0;
    tick(1);
    chk({tag, "_ok_clr"}, 32'(ok), 32'd0);
    tick(1);
  endtask

  initial begin
    song[0] = 25'(1 << 19);
    song[1] = 25'(1 << 18);
    song[2] = 25'h0001001;

    tick(3);
    rst_n = 1'b1;
    tick(1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ok", 32'(ok), 32'd0);
    chk("rst_note", 32'(note), 32'd0);
    chk("rst_cnt", 32'(cnt), 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    // exact play of a 3-step song
    for (int i = 0; i < 3; i++) wr(CW'(i), song[i]);
    go(7'd3, 1'b0, 1'b0);
    tick(1);
    chk("s_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("s_cnt", 32'(cnt), 32'(i));
      chk("s_note", 32'(note), 32'(song[i]));
      play("s", song[i]);
    end
    chk("s_done", 32'(done), 32'd1);
    chk("s_busy_end", 32'(busy), 32'd0);
    chk("s_cnt_end", 32'(cnt), 32'd2);
    chk("s_err", 32'(err), 32'd0);
    chk("s_note_end", 32'(note), 32'd0);

    // hold one cycle short, restarted from DONE
    go(7'd3, 1'b0, 1'b0);
    tick(1);
    gpi = song[0];
    tick(HC - 1);
    chk("short_ok", 32'(ok), 32'd0);
    gpi = '0;
    tick(2);
    chk("short_ok2", 32'(ok), 32'd0);
    chk("short_cnt", 32'(cnt), 32'd0);
    chk("short_busy", 32'(busy), 32'd1);

    // wrong key pressed twice, sustained second time
    gpi = 25'(1 << 5);
    tick(1);
    chk("w_pulse1", 32'(wrong), 32'd1);
    tick(1);
    chk("w_low1", 32'(wrong), 32'd0);
    gpi = '0;
    tick(2);
    gpi = 25'(1 << 5);
    tick(1);
    chk("w_pulse2", 32'(wrong), 32'd1);
    tick(3);
    chk("w_held", 32'(wrong), 32'd0);
    chk("w_err", 32'(err), 32'd2);
    gpi = '0;
    tick(1);
    play("w", song[0]);
    chk("w_err2", 32'(err), 32'd2);
    chk("w_cnt", 32'(cnt), 32'd1);

    // abort keeps err and cnt
    do_abort();
    chk("ab_busy", 32'(busy), 32'd0);
    chk("ab_err", 32'(err), 32'd2);
    chk("ab_cnt", 32'(cnt), 32'd1);

    // illegal lengths are ignored
    go(7'd0, 1'b0, 1'b0);
    tick(1);
    chk("len0_busy", 32'(busy), 32'd0);
    chk("len0_err", 32'(err), 32'd2);
    go(7'd65, 1'b0, 1'b0);
    tick(1);
    chk("len65_busy", 32'(busy), 32'd0);

    // loop mode with a write attempted while busy
    go(7'd2, 1'b0, 1'b1);
    tick(1);
    wr(6'd0, 25'(1 << 3));
    chk("lp_note0", 32'(note), 32'(song[0]));
    play("lp0", song[0]);
    play("lp1", song[1]);
    chk("lp_cnt", 32'(cnt), 32'd0);
    chk("lp_done", 32'(done), 32'd0);
    chk("lp_busy", 32'(busy), 32'd1);
    chk("lp_ram", 32'(note), 32'(song[0]));
    do_abort();
    chk("lp_ab_busy", 32'(busy), 32'd0);
    chk("lp_ab_done", 32'(done), 32'd0);

    // timed mode, no input
    go(7'd3, 1'b1, 1'b0);
    tick(60);
    chk("t_cnt60", 32'(cnt), 32'd0);
    chk("t_err60", 32'(err), 32'd0);
    tick(42);
    chk("t_cnt1", 32'(cnt), 32'd1);
    chk("t_err1", 32'(err), 32'd1);
    begin
      int n = 0;
      while (!done && n < 1000) begin
        tick(1);
        n++;
      end
    end
    chk("t_done", 32'(done), 32'd1);
    chk("t_err", 32'(err), 32'd3);
    chk("t_cnt", 32'(cnt), 32'd2);

    // error counter saturation
    go(7'd1, 1'b0, 1'b0);
    tick(1);
    for (int i = 0; i < 260; i++) begin
      gpi = 25'(1 << 5);
      tick(1);
      gpi = '0;
      tick(1);
    end
    chk("sat_err", 32'(err), 32'hff);
    do_abort();

    // reset while holding step 1
    go(7'd3, 1'b0, 1'b0);
    tick(1);
    play("r", song[0]);
    gpi = song[1];
    tick(4);
    rst_n = 1'b0;
    #2;
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_note", 32'(note), 32'd0);
    chk("mr_cnt", 32'(cnt), 32'd0);
    chk("mr_ok", 32'(ok), 32'd0);
    gpi = '0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    chk("mr_idle", 32'(busy), 32'd0);
    chk("mr_done", 32'(done), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
